// File: rtl/cci_c0_rd_arbiter.sv
// cci_c0_rd_arbiter
// Shares the CCI TX channel-0 read-request port among NUM_REQ requesters
// using round-robin arbitration. The winner's index is stamped into the top
// mdata bits of the issued header. Returning rx_c0 read responses are steered
// back to the issuing requester by that tag. The number of in-flight reads is
// capped at MAX_OUTST.
module cci_c0_rd_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int TX_HDR_W  = 61,
   parameter int RX_HDR_W  = 18,
   parameter int MAX_OUTST = 64
) (
   input  logic                                clk_32ui,
   input  logic                                sys_reset,
   input  logic                                lp_initdone,
   input  logic                                drain_req,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [NUM_REQ*TX_HDR_W-1:0]         req_hdr,
   output logic [NUM_REQ-1:0]                  req_ready,
   output logic [TX_HDR_W-1:0]                 tx_c0_header,
   output logic                                tx_c0_rdvalid,
   input  logic                                tx_c0_almostfull,
   input  logic [RX_HDR_W-1:0]                 rx_c0_header,
   input  logic                                rx_c0_rdvalid,
   output logic [NUM_REQ-1:0]                  rsp_valid,
   output logic [RX_HDR_W-1:0]                 rsp_hdr,
   output logic [$clog2(MAX_OUTST+1)-1:0]      outst_cnt,
   output logic                                drain_done,
   output logic [1:0]                          err_flags
);

   localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_OUTST + 1);

   localparam logic [TAG_W:0]   NUM_REQ_T = (TAG_W+1)'(NUM_REQ);
   localparam logic [TAG_W-1:0] LAST_REQ  = TAG_W'(NUM_REQ - 1);
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_OUTST);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [TAG_W-1:0]      r_rr_ptr;
   logic [CNT_W-1:0]      r_outst_cnt;
   logic [CNT_W-1:0]      w_cnt_nxt;
   logic                  r_tx_valid;
   logic [TX_HDR_W-1:0]   r_tx_hdr;
   logic [NUM_REQ-1:0]    r_rsp_valid;
   logic [RX_HDR_W-1:0]   r_rsp_hdr;
   logic                  r_drain_done;
   logic [1:0]            r_err;

   logic                  w_grant_en;
   logic                  w_grant;
   logic                  w_found;
   logic [TAG_W-1:0]      w_winner;
   logic [TAG_W:0]        w_idx;
   logic [TX_HDR_W-1:0]   w_sel_hdr;
   logic [TX_HDR_W-1:0]   w_stamped_hdr;
   logic [TAG_W-1:0]      w_tag;
   logic                  w_tag_ok;
   logic                  w_underflow;
   logic [NUM_REQ-1:0]    w_rsp_onehot;
   logic [RX_HDR_W-1:0]   w_rsp_hdr_clr;

   assign w_grant_en  = (r_state == ST_RUN) && !tx_c0_almostfull && (r_outst_cnt < MAX_CNT);
   assign w_grant     = w_grant_en && w_found;
   assign w_tag       = rx_c0_header[13 -: TAG_W];
   assign w_tag_ok    = {1'b0, w_tag} < NUM_REQ_T;
   assign w_underflow = rx_c0_rdvalid && !w_grant && (r_outst_cnt == '0);

   // Link-down forces INIT from anywhere; otherwise drain_req toggles RUN/DRAIN
   always_comb begin
      w_state_nxt = r_state;
      if (!lp_initdone) begin
         w_state_nxt = ST_INIT;
      end else begin
         case (r_state)
            ST_INIT:  w_state_nxt = ST_RUN;
            ST_RUN:   if (drain_req)  w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (!drain_req) w_state_nxt = ST_RUN;
            default:  w_state_nxt = ST_INIT;
         endcase
      end
   end

   // Round-robin search for the first valid requester starting at rr_ptr
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = {1'b0, r_rr_ptr} + k[TAG_W:0];
         if (w_idx >= NUM_REQ_T) begin
            w_idx = w_idx - NUM_REQ_T;
         end
         if (!w_found && req_valid[w_idx[TAG_W-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_idx[TAG_W-1:0];
         end
      end
   end

   // One-hot accept strobe and the winner's header with its tag stamped in
   always_comb begin
      req_ready = '0;
      w_sel_hdr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_winner == TAG_W'(i)) begin
            req_ready[i] = w_grant;
            w_sel_hdr    = req_hdr[i*TX_HDR_W +: TX_HDR_W];
         end
      end
      w_stamped_hdr                = w_sel_hdr;
      w_stamped_hdr[13 -: TAG_W]   = w_winner;
   end

   // In-flight count: grant and response in the same cycle cancel out
   always_comb begin
      w_cnt_nxt = r_outst_cnt;
      if (w_grant && !rx_c0_rdvalid) begin
         w_cnt_nxt = r_outst_cnt + 1'b1;
      end else if (!w_grant && rx_c0_rdvalid && (r_outst_cnt != '0)) begin
         w_cnt_nxt = r_outst_cnt - 1'b1;
      end
   end

   // Response steering by tag, with the tag bits cleared in the forwarded header
   always_comb begin
      w_rsp_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_tag == TAG_W'(i)) begin
            w_rsp_onehot[i] = rx_c0_rdvalid;
         end
      end
      w_rsp_hdr_clr              = rx_c0_header;
      w_rsp_hdr_clr[13 -: TAG_W] = '0;
   end

   // State, round-robin pointer and in-flight counter
   always_ff @(posedge clk_32ui or posedge sys_reset) begin
      if (sys_reset) begin
         r_state     <= ST_INIT;
         r_rr_ptr    <= '0;
         r_outst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_outst_cnt <= w_cnt_nxt;
         if (w_grant) begin
            r_rr_ptr <= (w_winner == LAST_REQ) ? '0 : w_winner + 1'b1;
         end
      end
   end

   // Registered request toward CCI; header only changes when a new request issues
   always_ff @(posedge clk_32ui or posedge sys_reset) begin
      if (sys_reset) begin
         r_tx_valid <= 1'b0;
         r_tx_hdr   <= '0;
      end else begin
         r_tx_valid <= w_grant;
         if (w_grant) begin
            r_tx_hdr <= w_stamped_hdr;
         end
      end
   end

   // Registered response pulse; header holds between responses and on bad tags
   always_ff @(posedge clk_32ui or posedge sys_reset) begin
      if (sys_reset) begin
         r_rsp_valid <= '0;
         r_rsp_hdr   <= '0;
      end else begin
         r_rsp_valid <= w_rsp_onehot;
         if (rx_c0_rdvalid && w_tag_ok) begin
            r_rsp_hdr <= w_rsp_hdr_clr;
         end
      end
   end

   // Drain completion tracks the next-cycle state and count; error flags are sticky
   always_ff @(posedge clk_32ui or posedge sys_reset) begin
      if (sys_reset) begin
         r_drain_done <= 1'b0;
         r_err        <= 2'b00;
      end else begin
         r_drain_done <= (w_state_nxt == ST_DRAIN) && (w_cnt_nxt == '0);
         if (w_underflow) begin
            r_err[0] <= 1'b1;
         end
         if (rx_c0_rdvalid && !w_tag_ok) begin
            r_err[1] <= 1'b1;
         end
      end
   end

   assign tx_c0_rdvalid = r_tx_valid;
   assign tx_c0_header  = r_tx_hdr;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_hdr       = r_rsp_hdr;
   assign outst_cnt     = r_outst_cnt;
   assign drain_done    = r_drain_done;
   assign err_flags     = r_err;

endmodule

// File: tb/tb_cci_c0_rd_arbiter.sv
// tb_cci_c0_rd_arbiter
// Directed bench for the channel-0 read arbiter. Instance A uses the default
// configuration (4 requesters, 64 outstanding); instance B uses 3 requesters
// and a limit of 4 outstanding reads to reach the cap and the bad-tag case.
module tb_cci_c0_rd_arbiter;

   logic clk_32ui = 1'b0;
   logic sys_reset;

   logic          initA, drainA, afA, rxValidA;
   logic [3:0]    reqValidA;
   logic [243:0]  reqHdrA;
   logic [17:0]   rxHdrA;
   logic [3:0]    reqReadyA, rspValidA;
   logic [60:0]   txHdrA;
   logic          txValidA, drainDoneA;
   logic [17:0]   rspHdrA;
   logic [6:0]    outstA;
   logic [1:0]    errA;

   logic          initB, drainB, afB, rxValidB;
   logic [2:0]    reqValidB;
   logic [182:0]  reqHdrB;
   logic [17:0]   rxHdrB;
   logic [2:0]    reqReadyB, rspValidB;
   logic [60:0]   txHdrB;
   logic          txValidB, drainDoneB;
   logic [17:0]   rspHdrB;
   logic [2:0]    outstB;
   logic [1:0]    errB;

   int errors;
   int checks;

   cci_c0_rd_arbiter dutA (
      .clk_32ui(clk_32ui), .sys_reset(sys_reset), .lp_initdone(initA), .drain_req(drainA),
      .req_valid(reqValidA), .req_hdr(reqHdrA), .req_ready(reqReadyA),
      .tx_c0_header(txHdrA), .tx_c0_rdvalid(txValidA), .tx_c0_almostfull(afA),
      .rx_c0_header(rxHdrA), .rx_c0_rdvalid(rxValidA),
      .rsp_valid(rspValidA), .rsp_hdr(rspHdrA), .outst_cnt(outstA),
      .drain_done(drainDoneA), .err_flags(errA)
   );

   cci_c0_rd_arbiter #(.NUM_REQ(3), .MAX_OUTST(4)) dutB (
      .clk_32ui(clk_32ui), .sys_reset(sys_reset), .lp_initdone(initB), .drain_req(drainB),
      .req_valid(reqValidB), .req_hdr(reqHdrB), .req_ready(reqReadyB),
      .tx_c0_header(txHdrB), .tx_c0_rdvalid(txValidB), .tx_c0_almostfull(afB),
      .rx_c0_header(rxHdrB), .rx_c0_rdvalid(rxValidB),
      .rsp_valid(rspValidB), .rsp_hdr(rspHdrB), .outst_cnt(outstB),
      .drain_done(drainDoneB), .err_flags(errB)
   );

   // Free-running clock
   always #5 clk_32ui = ~clk_32ui;

   // Hard stop in case the sequence ever stalls
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [60:0] hdrOf(input int i);
      return {47'(4096 + i), 14'h3FFF};
   endfunction

   function automatic logic [60:0] stampedOf(input int i);
      logic [60:0] h;
      logic [1:0]  t;
      h = hdrOf(i);
      t = 2'(i);
      h[13:12] = t;
      return h;
   endfunction

   task automatic step();
      @(posedge clk_32ui);
      #1;
   endtask

   task automatic test_reset();
      sys_reset = 1'b1;
      reqValidA = 4'hF;
      reqValidB = 3'h7;
      repeat (3) step();
      checks++; if (txValidA !== 1'b0)   begin errors++; $display("[TB] FAIL reset_txvalid: got %b want 0", txValidA); end
      checks++; if (txHdrA !== 61'd0)    begin errors++; $display("[TB] FAIL reset_txhdr: got %h want 0", txHdrA); end
      checks++; if (rspValidA !== 4'd0)  begin errors++; $display("[TB] FAIL reset_rspvalid: got %b want 0", rspValidA); end
      checks++; if (rspHdrA !== 18'd0)   begin errors++; $display("[TB] FAIL reset_rsphdr: got %h want 0", rspHdrA); end
      checks++; if (outstA !== 7'd0)     begin errors++; $display("[TB] FAIL reset_outst: got %0d want 0", outstA); end
      checks++; if (drainDoneA !== 1'b0) begin errors++; $display("[TB] FAIL reset_draindone: got %b want 0", drainDoneA); end
      checks++; if (errA !== 2'b00)      begin errors++; $display("[TB] FAIL reset_err: got %b want 00", errA); end
      checks++; if (reqReadyA !== 4'd0)  begin errors++; $display("[TB] FAIL reset_ready: got %b want 0", reqReadyA); end
      sys_reset = 1'b0;
      step();
      checks++; if (reqReadyA !== 4'd0)  begin errors++; $display("[TB] FAIL init_ready_a: got %b want 0", reqReadyA); end
      checks++; if (reqReadyB !== 3'd0)  begin errors++; $display("[TB] FAIL init_ready_b: got %b want 0", reqReadyB); end
   endtask

   task automatic test_round_robin();
      logic [3:0] expReady;
      initA = 1'b1;
      step();
      for (int k = 0; k < 8; k++) begin
         expReady = 4'b0001 << (k % 4);
         checks++; if (reqReadyA !== expReady) begin errors++; $display("[TB] FAIL rr_ready[%0d]: got %b want %b", k, reqReadyA, expReady); end
         checks++; if (outstA !== 7'(k))       begin errors++; $display("[TB] FAIL rr_outst[%0d]: got %0d want %0d", k, outstA, k); end
         if (k > 0) begin
            checks++; if (txValidA !== 1'b1) begin errors++; $display("[TB] FAIL rr_txvalid[%0d]: got %b want 1", k, txValidA); end
            checks++; if (txHdrA !== stampedOf((k - 1) % 4)) begin errors++; $display("[TB] FAIL rr_txhdr[%0d]: got %h want %h", k, txHdrA, stampedOf((k - 1) % 4)); end
         end
         step();
      end
   endtask

   task automatic test_almostfull();
      afA = 1'b1;
      #1;
      checks++; if (txHdrA !== stampedOf(3)) begin errors++; $display("[TB] FAIL af_lasthdr: got %h want %h", txHdrA, stampedOf(3)); end
      for (int k = 0; k < 5; k++) begin
         checks++; if (reqReadyA !== 4'd0) begin errors++; $display("[TB] FAIL af_ready[%0d]: got %b want 0", k, reqReadyA); end
         checks++; if (txValidA !== (k == 0)) begin errors++; $display("[TB] FAIL af_txvalid[%0d]: got %b want %b", k, txValidA, (k == 0)); end
         checks++; if (outstA !== 7'd8)    begin errors++; $display("[TB] FAIL af_outst[%0d]: got %0d want 8", k, outstA); end
         step();
      end
      afA = 1'b0;
      #1;
      checks++; if (txValidA !== 1'b0)     begin errors++; $display("[TB] FAIL af_tail_txvalid: got %b want 0", txValidA); end
      checks++; if (reqReadyA !== 4'b0001) begin errors++; $display("[TB] FAIL af_resume_ready: got %b want 0001", reqReadyA); end
      step();
      checks++; if (txValidA !== 1'b1)       begin errors++; $display("[TB] FAIL af_resume_txvalid: got %b want 1", txValidA); end
      checks++; if (txHdrA !== stampedOf(0)) begin errors++; $display("[TB] FAIL af_resume_txhdr: got %h want %h", txHdrA, stampedOf(0)); end
      checks++; if (outstA !== 7'd9)         begin errors++; $display("[TB] FAIL af_resume_outst: got %0d want 9", outstA); end
   endtask

   task automatic test_grant_and_response();
      rxHdrA   = 18'h3EFFF;
      rxValidA = 1'b1;
      #1;
      checks++; if (reqReadyA !== 4'b0010) begin errors++; $display("[TB] FAIL gr_ready: got %b want 0010", reqReadyA); end
      step();
      rxValidA  = 1'b0;
      reqValidA = 4'h0;
      #1;
      checks++; if (outstA !== 7'd9)         begin errors++; $display("[TB] FAIL gr_outst: got %0d want 9", outstA); end
      checks++; if (rspValidA !== 4'b0100)   begin errors++; $display("[TB] FAIL gr_rspvalid: got %b want 0100", rspValidA); end
      checks++; if (rspHdrA !== 18'h3CFFF)   begin errors++; $display("[TB] FAIL gr_rsphdr: got %h want 3cfff", rspHdrA); end
      checks++; if (txHdrA !== stampedOf(1)) begin errors++; $display("[TB] FAIL gr_txhdr: got %h want %h", txHdrA, stampedOf(1)); end
      step();
      checks++; if (rspValidA !== 4'd0)      begin errors++; $display("[TB] FAIL gr_rsp_pulse: got %b want 0", rspValidA); end
      checks++; if (rspHdrA !== 18'h3CFFF)   begin errors++; $display("[TB] FAIL gr_rsphdr_hold: got %h want 3cfff", rspHdrA); end
      checks++; if (txValidA !== 1'b0)       begin errors++; $display("[TB] FAIL gr_txvalid_idle: got %b want 0", txValidA); end
   endtask

   task automatic test_drain();
      rxHdrA   = 18'h00000;
      rxValidA = 1'b1;
      repeat (6) step();
      rxValidA = 1'b0;
      #1;
      checks++; if (outstA !== 7'd3)       begin errors++; $display("[TB] FAIL dr_pre_outst: got %0d want 3", outstA); end
      checks++; if (rspValidA !== 4'b0001) begin errors++; $display("[TB] FAIL dr_pre_rspvalid: got %b want 0001", rspValidA); end
      drainA = 1'b1;
      step();
      reqValidA = 4'hF;
      #1;
      checks++; if (reqReadyA !== 4'd0)    begin errors++; $display("[TB] FAIL dr_ready: got %b want 0", reqReadyA); end
      checks++; if (drainDoneA !== 1'b0)   begin errors++; $display("[TB] FAIL dr_done_early: got %b want 0", drainDoneA); end
      for (int k = 0; k < 3; k++) begin
         rxValidA = 1'b1;
         #1;
         checks++; if (reqReadyA !== 4'd0) begin errors++; $display("[TB] FAIL dr_ready_rsp[%0d]: got %b want 0", k, reqReadyA); end
         step();
         rxValidA = 1'b0;
         #1;
         checks++; if (outstA !== 7'(2 - k))       begin errors++; $display("[TB] FAIL dr_outst[%0d]: got %0d want %0d", k, outstA, 2 - k); end
         checks++; if (drainDoneA !== (k == 2))   begin errors++; $display("[TB] FAIL dr_done[%0d]: got %b want %b", k, drainDoneA, (k == 2)); end
      end
      drainA = 1'b0;
      #1;
      checks++; if (reqReadyA !== 4'd0)    begin errors++; $display("[TB] FAIL dr_release_ready: got %b want 0", reqReadyA); end
      step();
      checks++; if (drainDoneA !== 1'b0)   begin errors++; $display("[TB] FAIL dr_done_clear: got %b want 0", drainDoneA); end
      checks++; if (reqReadyA !== 4'b0100) begin errors++; $display("[TB] FAIL dr_resume_ready: got %b want 0100", reqReadyA); end
      checks++; if (errA !== 2'b00)        begin errors++; $display("[TB] FAIL dr_err: got %b want 00", errA); end
      reqValidA = 4'h0;
   endtask

   task automatic test_max_outstanding();
      logic [2:0] expReady;
      initB = 1'b1;
      step();
      for (int k = 0; k < 4; k++) begin
         expReady = 3'b001 << (k % 3);
         checks++; if (reqReadyB !== expReady) begin errors++; $display("[TB] FAIL mx_ready[%0d]: got %b want %b", k, reqReadyB, expReady); end
         checks++; if (outstB !== 3'(k))       begin errors++; $display("[TB] FAIL mx_outst[%0d]: got %0d want %0d", k, outstB, k); end
         step();
      end
      checks++; if (txHdrB !== stampedOf(0)) begin errors++; $display("[TB] FAIL mx_txhdr: got %h want %h", txHdrB, stampedOf(0)); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (reqReadyB !== 3'd0) begin errors++; $display("[TB] FAIL mx_cap_ready[%0d]: got %b want 0", k, reqReadyB); end
         checks++; if (outstB !== 3'd4)    begin errors++; $display("[TB] FAIL mx_cap_outst[%0d]: got %0d want 4", k, outstB); end
         step();
      end
      rxHdrB   = 18'h00000;
      rxValidB = 1'b1;
      #1;
      checks++; if (reqReadyB !== 3'd0)    begin errors++; $display("[TB] FAIL mx_rsp_ready: got %b want 0", reqReadyB); end
      step();
      rxValidB = 1'b0;
      #1;
      checks++; if (outstB !== 3'd3)       begin errors++; $display("[TB] FAIL mx_rsp_outst: got %0d want 3", outstB); end
      checks++; if (rspValidB !== 3'b001)  begin errors++; $display("[TB] FAIL mx_rspvalid: got %b want 001", rspValidB); end
      checks++; if (reqReadyB !== 3'b010)  begin errors++; $display("[TB] FAIL mx_regrant: got %b want 010", reqReadyB); end
      step();
      checks++; if (outstB !== 3'd4)         begin errors++; $display("[TB] FAIL mx_refill_outst: got %0d want 4", outstB); end
      checks++; if (reqReadyB !== 3'd0)      begin errors++; $display("[TB] FAIL mx_refill_ready: got %b want 0", reqReadyB); end
      checks++; if (txHdrB !== stampedOf(1)) begin errors++; $display("[TB] FAIL mx_refill_txhdr: got %h want %h", txHdrB, stampedOf(1)); end
   endtask

   task automatic test_bad_tag_underflow();
      reqValidB = 3'h0;
      rxHdrB    = 18'h03000;
      rxValidB  = 1'b1;
      step();
      rxValidB = 1'b0;
      #1;
      checks++; if (rspValidB !== 3'd0)  begin errors++; $display("[TB] FAIL bt_rspvalid: got %b want 0", rspValidB); end
      checks++; if (errB !== 2'b10)      begin errors++; $display("[TB] FAIL bt_err: got %b want 10", errB); end
      checks++; if (outstB !== 3'd3)     begin errors++; $display("[TB] FAIL bt_outst: got %0d want 3", outstB); end
      rxHdrB   = 18'h01000;
      rxValidB = 1'b1;
      repeat (3) step();
      rxValidB = 1'b0;
      #1;
      checks++; if (outstB !== 3'd0)       begin errors++; $display("[TB] FAIL uf_pre_outst: got %0d want 0", outstB); end
      checks++; if (rspValidB !== 3'b010)  begin errors++; $display("[TB] FAIL uf_pre_rspvalid: got %b want 010", rspValidB); end
      checks++; if (errB !== 2'b10)        begin errors++; $display("[TB] FAIL uf_pre_err: got %b want 10", errB); end
      rxValidB = 1'b1;
      step();
      rxValidB = 1'b0;
      #1;
      checks++; if (errB !== 2'b11)        begin errors++; $display("[TB] FAIL uf_err: got %b want 11", errB); end
      checks++; if (outstB !== 3'd0)       begin errors++; $display("[TB] FAIL uf_outst: got %0d want 0", outstB); end
   endtask

   task automatic test_async_reset();
      #1;
      sys_reset = 1'b1;
      #1;
      checks++; if (errB !== 2'b00)      begin errors++; $display("[TB] FAIL ar_err: got %b want 00", errB); end
      checks++; if (outstA !== 7'd0)     begin errors++; $display("[TB] FAIL ar_outst: got %0d want 0", outstA); end
      checks++; if (rspHdrA !== 18'd0)   begin errors++; $display("[TB] FAIL ar_rsphdr: got %h want 0", rspHdrA); end
      sys_reset = 1'b0;
      step();
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      sys_reset = 1'b1;
      initA = 1'b0; drainA = 1'b0; afA = 1'b0; rxValidA = 1'b0; rxHdrA = '0; reqValidA = '0;
      initB = 1'b0; drainB = 1'b0; afB = 1'b0; rxValidB = 1'b0; rxHdrB = '0; reqValidB = '0;
      reqHdrA = '0;
      reqHdrB = '0;
      for (int i = 0; i < 4; i++) reqHdrA[i*61 +: 61] = hdrOf(i);
      for (int i = 0; i < 3; i++) reqHdrB[i*61 +: 61] = hdrOf(i);
      $display("[TB] starting cci_c0_rd_arbiter bench");
      test_reset();
      test_round_robin();
      test_almostfull();
      test_grant_and_response();
      test_drain();
      test_max_outstanding();
      test_bad_tag_underflow();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cci_c0_rd_arbiter.md
# cci_c0_rd_arbiter

Round-robin arbiter that shares the CCI TX channel-0 read-request port (tx_c0_header / tx_c0_rdvalid / tx_c0_almostfull) among NUM_REQ requesters inside cci_std_afu. It stamps a requester ID into the request mdata and limits outstanding reads. Returning rx_c0 read responses are steered back to the issuing requester by that ID. rx_c0_data is not routed here; requesters sample the shared rx_c0_data bus when their rsp_valid is asserted.

## Interface
- NUM_REQ, 4: number of requesters, 2..8. TAG_W = max(1, clog2(NUM_REQ)).
- TX_HDR_W, 61: TX header width; mdata = hdr[13:0].
- RX_HDR_W, 18: RX header width; mdata = hdr[13:0].
- MAX_OUTST, 64: maximum in-flight reads, 1..256. CNT_W = clog2(MAX_OUTST+1).
- clk_32ui  in  1  sole clock.
- sys_reset  in  1  asynchronous, active-high reset.
- lp_initdone  in  1  link init complete.
- drain_req  in  1  stop issuing and wait for all responses.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_hdr  in  NUM_REQ*TX_HDR_W  per-requester header; requester i occupies bits [i*TX_HDR_W +: TX_HDR_W].
- req_ready  out  NUM_REQ  one-hot accept strobe (combinational).
- tx_c0_header  out  TX_HDR_W  registered header to CCI.
- tx_c0_rdvalid  out  1  registered request valid.
- tx_c0_almostfull  in  1  CCI flow control.
- rx_c0_header  in  RX_HDR_W  CCI response header.
- rx_c0_rdvalid  in  1  read response valid.
- rsp_valid  out  NUM_REQ  one-hot registered response strobe.
- rsp_hdr  out  RX_HDR_W  registered response header, tag bits cleared.
- outst_cnt  out  CNT_W  in-flight read count.
- drain_done  out  1  high in DRAIN while outst_cnt == 0.
- err_flags  out  2  sticky: [0] response underflow, [1] bad tag.

## Operation
- Decided: one clock (clk_32ui); sys_reset is asynchronous and active-high.
- Reset values: state INIT; rr_ptr = 0; outst_cnt = 0; tx_c0_rdvalid = 0; tx_c0_header = 0; rsp_valid = 0; rsp_hdr = 0; err_flags = 0; drain_done = 0.
- State transitions:
  - INIT -> RUN when lp_initdone = 1.
  - RUN -> DRAIN when drain_req = 1.
  - DRAIN -> RUN when drain_req = 0.
  - Any state -> INIT when lp_initdone = 0. outst_cnt is retained.
- Grant enable: state == RUN, tx_c0_almostfull == 0, outst_cnt < MAX_OUTST.
- Winner selection: the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready[winner] = 1; all other req_ready bits = 0.
  - After a grant, rr_ptr = (winner+1) mod NUM_REQ. With no grant, rr_ptr is unchanged.
- Header stamping: the issued header equals req_hdr[winner] with mdata[13 -: TAG_W] replaced by the winner index. Requesters must not rely on those bits.
- outst_cnt update: +1 on grant, -1 on rx_c0_rdvalid, unchanged when both occur in the same cycle.
  - rx_c0_rdvalid with outst_cnt == 0 and no same-cycle grant: count stays 0, err_flags[0] set.
- Response routing: tag = rx_c0_header[13 -: TAG_W].
  - Valid tag: rsp_valid[tag] = 1 and rsp_hdr = header with tag bits zeroed.
  - tag >= NUM_REQ: response dropped, err_flags[1] set, outst_cnt still decremented.
- rx_c0_wrvalid, cfgvalid, umsgvalid and intrvalid are ignored.

## Timing
- Request path: grant in cycle t gives tx_c0_rdvalid = 1 with the stamped header in cycle t+1. Latency is 1; at most one request per cycle.
- tx_c0_almostfull is sampled in cycle t: if high, no grant in t. Requests already registered still issue, and CCI absorbs them.
- Response path: rx_c0_rdvalid in cycle t gives rsp_valid/rsp_hdr in cycle t+1, one-cycle pulse. rsp_hdr holds its value when rsp_valid = 0.
- outst_cnt updates in the cycle after the grant or response that causes it.
- drain_done is registered.
- sys_reset mid-operation: all state clears immediately. In-flight responses arriving after reset trigger the underflow flag; software must reset only when idle.

## Test plan
- Reset then lp_initdone = 1, all four req_valid held high, no almostfull -> grants go 0,1,2,3,0,... one per cycle; tx_c0_rdvalid stays high continuously; mdata[13:12] = 0,1,2,3.
- tx_c0_almostfull high for cycles 10-14 with requesters active -> no req_ready in 10-14; tx_c0_rdvalid low in 11-15; round-robin resumes from the saved rr_ptr.
- MAX_OUTST = 4, no responses -> exactly 4 grants, then req_ready stays 0. One rx_c0_rdvalid -> exactly one more grant.
- Grant and rx_c0_rdvalid with tag 2 in the same cycle -> outst_cnt unchanged; rsp_valid = 4'b0100 in the next cycle; rsp_hdr[13:12] = 0.
- drain_req = 1 with 3 reads outstanding -> no new grants; drain_done rises the cycle after the third response; drain_req = 0 -> grants resume.
- NUM_REQ = 3, response with tag 3 -> no rsp_valid; err_flags = 2'b10. Response at outst_cnt = 0 -> err_flags[0] set.
